// File: rtl/speed_disp_pkg.sv
// Shared constants, FSM state type and segment encoder for the speed display.
package speed_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Active-low a..g code for one BCD nibble; non-decimal nibbles stay dark.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter: one bit per cycle, VAL_W cycles per conversion.
module bin2bcd_seq #(
  parameter int VAL_W      = 7,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [VAL_W-1:0]        bin_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    done
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    cnt_d = cnt_q;
    adj   = bcd_q;
    if (start) begin
      bcd_d = '0;
      bin_d = bin_in;
      cnt_d = CNT_W'(VAL_W);
    end else if (cnt_q != '0) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end
      {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Only the bit counter is control; the shift registers need no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    bcd_q <= bcd_d;
    bin_q <= bin_d;
  end

  // High during the final shift cycle so the caller can leave CONV on that edge.
  assign done    = (cnt_q == CNT_W'(1));
  assign bcd_out = bcd_q;

endmodule

// File: rtl/speed_display_seq.sv
// Sequential speed-deviation to 7-segment display driver.
// Optional leading-zero blanking is enabled by defining SPEED_DISP_LZB_EN.
module speed_display_seq
  import speed_disp_pkg::*;
#(
  parameter int VAL_W      = 7,
  parameter int OFFSET     = 27,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [VAL_W-1:0]        Speed,
  input  logic                    Load,
  input  logic                    DisplayEnable,
  output logic [7*NUM_DIGITS-1:0] Digits,
  output logic                    Negative,
  output logic                    Overflow,
  output logic                    Busy,
  output logic                    Valid
);

  localparam int               BCD_W   = 4 * NUM_DIGITS;
  localparam int               MAX_VAL = 10 ** NUM_DIGITS - 1;
  localparam logic [VAL_W-1:0] OFF_V   = VAL_W'(OFFSET);

  state_e                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic                    ovf_q, ovf_d;
  logic                    neg_q, neg_d;
  logic                    ovf_out_q, ovf_out_d;
  logic                    valid_q, valid_d;
  logic [BCD_W-1:0]        held_q, held_d;
  logic [7*NUM_DIGITS-1:0] digits_q, digits_d;

  logic                    below;
  logic [VAL_W-1:0]        mag;
  logic                    mag_ovf;
  logic                    conv_start;
  logic                    conv_done;
  logic [BCD_W-1:0]        conv_bcd;
`ifdef SPEED_DISP_LZB_EN
  logic                    lead_zero;
`endif

  // Magnitude of deviation from the centre; the subtraction never wraps.
  assign below   = (Speed < OFF_V);
  assign mag     = below ? (OFF_V - Speed) : (Speed - OFF_V);
  assign mag_ovf = (32'(mag) > 32'(MAX_VAL));

  bin2bcd_seq #(
    .VAL_W      (VAL_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (Clock),
    .rst_n   (Resetn),
    .start   (conv_start),
    .bin_in  (mag),
    .bcd_out (conv_bcd),
    .done    (conv_done)
  );

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    ovf_out_d  = ovf_out_q;
    held_d     = held_q;
    valid_d    = 1'b0;
    conv_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (Load) begin
          conv_start = 1'b1;
          sign_d     = below;
          ovf_d      = mag_ovf;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_d = LATCH;
      end
      LATCH: begin
        held_d    = ovf_q ? {NUM_DIGITS{4'd9}} : conv_bcd;
        neg_d     = sign_q;
        ovf_out_d = ovf_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    digits_d = {NUM_DIGITS{SEG_BLANK}};
`ifdef SPEED_DISP_LZB_EN
    lead_zero = 1'b1;
`endif
    if (DisplayEnable) begin
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
        digits_d[7*k +: 7] = seg_encode(held_q[4*k +: 4]);
`ifdef SPEED_DISP_LZB_EN
        lead_zero = lead_zero && (held_q[4*k +: 4] == 4'd0);
        if (lead_zero && (k != 0)) digits_d[7*k +: 7] = SEG_BLANK;
`endif
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      neg_q     <= 1'b0;
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
      held_q    <= '0;
      digits_q  <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
      digits_q  <= digits_d;
    end
  end

  // Capture flags are only read in LATCH after a Load, so they carry no reset.
  always_ff @(posedge Clock) begin
    sign_q <= sign_d;
    ovf_q  <= ovf_d;
  end

  assign Digits   = digits_q;
  assign Negative = neg_q;
  assign Overflow = ovf_out_q;
  assign Valid    = valid_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_speed_display_seq.sv
// Self-checking bench for speed_display_seq (3-digit and 2-digit instances share stimulus).
module tb_speed_display_seq;

  localparam int VAL_W = 7;
  localparam int OFFS  = 27;
`ifdef SPEED_DISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Load;
  logic        DisplayEnable;
  logic [6:0]  Speed;
  logic [20:0] Digits;
  logic        Negative, Overflow, Busy, Valid;
  logic [13:0] Digits2;
  logic        Negative2, Overflow2, Busy2, Valid2;

  int checks = 0;
  int errors = 0;
  logic [20:0] last_digits;

  speed_display_seq #(.VAL_W(VAL_W), .OFFSET(OFFS), .NUM_DIGITS(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .Speed(Speed), .Load(Load),
    .DisplayEnable(DisplayEnable), .Digits(Digits), .Negative(Negative),
    .Overflow(Overflow), .Busy(Busy), .Valid(Valid)
  );

  speed_display_seq #(.VAL_W(VAL_W), .OFFSET(OFFS), .NUM_DIGITS(2)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .Speed(Speed), .Load(Load),
    .DisplayEnable(DisplayEnable), .Digits(Digits2), .Negative(Negative2),
    .Overflow(Overflow2), .Busy(Busy2), .Valid(Valid2)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_tbl(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int mag_of(input int s);
    return (s < OFFS) ? OFFS - s : s - OFFS;
  endfunction

  // Decimal rendering of a magnitude, clamped to all nines on overflow.
  function automatic logic [20:0] model_digits(input int mag, input int nd);
    logic [20:0] r;
    int lim, v, p;
    r   = '1;
    lim = (nd == 3) ? 999 : 99;
    v   = (mag > lim) ? lim : mag;
    p   = 1;
    for (int k = 0; k < nd; k++) begin
      r[7*k +: 7] = seg_tbl((v / p) % 10);
      if (LZB && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (Valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_conv(input int spd);
    int n, m;
    logic [20:0] e;
    logic [13:0] e2;
    m = mag_of(spd);
    Speed = 7'(spd);
    Load  = 1'b1;
    step();
    Load  = 1'b0;
    chk("busy_after_load", 32'(Busy), 32'(1'b1));
    chk("hold_during_conv", 32'(Digits), 32'(last_digits));
    wait_valid(n);
    chk("latency", 32'(n), 32'(VAL_W + 1));
    chk("negative", 32'(Negative), 32'(spd < OFFS));
    chk("overflow", 32'(Overflow), 32'(1'b0));
    chk("negative2", 32'(Negative2), 32'(spd < OFFS));
    chk("overflow2", 32'(Overflow2), 32'(m > 99));
    step();
    chk("valid_one_cycle", 32'(Valid), 32'(1'b0));
    chk("busy_idle", 32'(Busy), 32'(1'b0));
    e  = model_digits(m, 3);
    chk("digits", 32'(Digits), 32'(e));
    e  = model_digits(m, 2);
    e2 = e[13:0];
    chk("digits2", 32'(Digits2), 32'(e2));
    last_digits = model_digits(m, 3);
  endtask

  initial begin
    int n, vcnt;
    logic [20:0] e;

    Resetn = 1'b0; Load = 1'b0; DisplayEnable = 1'b1; Speed = '0;
    step();
    step();
    chk("rst_digits", 32'(Digits), 32'(21'h1FFFFF));
    chk("rst_negative", 32'(Negative), 32'(1'b0));
    chk("rst_overflow", 32'(Overflow), 32'(1'b0));
    chk("rst_busy", 32'(Busy), 32'(1'b0));
    chk("rst_valid", 32'(Valid), 32'(1'b0));
    Resetn = 1'b1;
    step();
    e = model_digits(0, 3);
    chk("post_rst_zero", 32'(Digits), 32'(e));
    last_digits = e;

    // Directed points: centre, below centre, top of range.
    run_conv(27);
    run_conv(0);
    run_conv(127);

    // A second Load during CONV is dropped.
    Speed = 7'd50; Load = 1'b1;
    step();
    Speed = 7'd10;
    step();
    Load = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (Valid) vcnt++;
    end
    chk("ignored_load_valids", 32'(vcnt), 32'(1));
    chk("ignored_load_neg", 32'(Negative), 32'(1'b0));
    e = model_digits(23, 3);
    chk("ignored_load_digits", 32'(Digits), 32'(e));
    last_digits = e;

    // Display disable mid-run, then re-enable with no new Load.
    Speed = 7'd90; Load = 1'b1;
    step();
    Load = 1'b0;
    step();
    DisplayEnable = 1'b0;
    step();
    chk("disable_blank", 32'(Digits), 32'(21'h1FFFFF));
    chk("disable_blank2", 32'(Digits2), 32'(14'h3FFF));
    wait_valid(n);
    chk("disable_conv_done", 32'(n > 0), 32'(1'b1));
    step();
    chk("disable_still_blank", 32'(Digits), 32'(21'h1FFFFF));
    DisplayEnable = 1'b1;
    step();
    e = model_digits(63, 3);
    chk("reenable_digits", 32'(Digits), 32'(e));
    last_digits = e;

    // Load tied high: back-to-back period.
    Speed = 7'd40; Load = 1'b1;
    wait_valid(n);
    chk("tied_first", 32'(n), 32'(VAL_W + 2));
    wait_valid(n);
    chk("tied_period", 32'(n), 32'(VAL_W + 2));
    Load = 1'b0;
    step();
    chk("tied_busy_low", 32'(Busy), 32'(1'b0));
    e = model_digits(13, 3);
    chk("tied_digits", 32'(Digits), 32'(e));
    last_digits = e;

    // Reset in the third CONV cycle aborts without committing.
    Speed = 7'd100; Load = 1'b1;
    step();
    Load = 1'b0;
    step();
    step();
    Resetn = 1'b0;
    step();
    Resetn = 1'b1;
    chk("midrst_busy", 32'(Busy), 32'(1'b0));
    chk("midrst_digits", 32'(Digits), 32'(21'h1FFFFF));
    chk("midrst_valid", 32'(Valid), 32'(1'b0));
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (Valid) vcnt++;
    end
    chk("midrst_no_valid", 32'(vcnt), 32'(0));
    e = model_digits(0, 3);
    chk("midrst_zero_shown", 32'(Digits), 32'(e));
    last_digits = e;
    run_conv(int'($urandom_range(0, 127)));

    // Randomised conversions.
    for (int i = 0; i < 8; i++) run_conv(int'($urandom_range(0, 127)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/speed_display_seq.md
Name: speed_display_seq

Overview:
- Parametrised, sequential successor to the combinational speed-to-7-segment converter.
- Captures a speed sample on request and forms the magnitude of its deviation from a programmable centre value, plus a sign flag.
- Converts the magnitude to BCD with an iterative shift-add-3 (double-dabble) engine, then drives NUM_DIGITS registered active-low 7-segment outputs.
- Sits between the car speed register and the HEX display drivers; the held display does not flicker while a conversion is running.

Parameters:
VAL_W, 7, width of Speed input; also the magnitude width.
OFFSET, 27, centre speed; requires OFFSET <= 2^VAL_W-1.
NUM_DIGITS, 3, number of decimal digits driven; BCD width is 4*NUM_DIGITS.

Ports:
Clock  in  1  system clock; all state updates on the rising edge.
Resetn  in  1  synchronous, active-low reset.
Speed  in  VAL_W  raw speed value.
Load  in  1  conversion request; sampled only in IDLE.
DisplayEnable  in  1  0 = all segments dark.
Digits  out  7*NUM_DIGITS  segment codes; digit k (k=0 ones) at bits [7k+6:7k].
Negative  out  1  registered; 1 when the captured Speed < OFFSET.
Overflow  out  1  registered; 1 when the magnitude exceeds 10^NUM_DIGITS-1.
Busy  out  1  high in CONV and LATCH.
Valid  out  1  one-cycle pulse when a new result is committed.

Behaviour:
- Interface: one clock (Clock); reset Resetn is synchronous and active-low.
- Segment encoding: active-low, bit6=a … bit0=g.
  - Codes: BLANK=1111111, 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Reset (Resetn=0 at an edge): Digits=all BLANK, Negative=0, Overflow=0, Busy=0, Valid=0, state=IDLE. The held value register is set to all-zero BCD.
- Reset mid-conversion: the conversion aborts with no partial commit.
- FSM states IDLE, CONV, LATCH:
  - IDLE:
    - If Load=1, capture at the edge:
      - mag = (Speed<OFFSET) ? OFFSET-Speed : Speed-OFFSET, computed at VAL_W bits with no wrap.
      - sign = (Speed<OFFSET).
      - ovf = (mag > 10^NUM_DIGITS-1).
    - Then clear the BCD accumulator, set bit counter = VAL_W, go to CONV.
  - CONV:
    - Each cycle: every BCD nibble >=5 gets +3, then {bcd,mag} shifts left by 1 and the counter decrements.
    - After exactly VAL_W cycles, go to LATCH.
  - LATCH:
    - Held BCD <= ovf ? all 9s : accumulator.
    - Negative <= sign; Overflow <= ovf.
    - Return to IDLE.
- Valid pulses for exactly the one cycle after the LATCH edge.
- Latency: Load sampled at edge E; new held value and Valid are visible after edge E+VAL_W+1.
- Load while Busy=1 is ignored, with no queueing.
- Load held high re-triggers on the first IDLE cycle, so with Load tied high the back-to-back period is VAL_W+2 cycles.
- Output stage, updated every cycle:
  - Digits <= DisplayEnable ? encode(held BCD) : all BLANK.
  - One-cycle latency from DisplayEnable and from a held-value change.
  - The held value is retained while DisplayEnable=0.
- During CONV/LATCH, Digits keep showing the previous result.

Optional Feature:
SPEED_DISP_LZB_EN:
- Defined: leading-zero blanking. Any digit k>0 whose nibble and all higher nibbles are 0 shows BLANK; digit 0 is never blanked. Overflow display (all 9s) is unaffected.
- Undefined: all NUM_DIGITS digits are always shown, including leading zeros.

Decomposition:
- Package speed_disp_pkg holds:
  - the segment code constants listed above plus BLANK;
  - the FSM state enum {IDLE, CONV, LATCH};
  - a seg_encode function (4-bit nibble -> 7-bit code, non-decimal -> BLANK).
- One sub-module, bin2bcd_seq: the iterative double-dabble engine, with start/done, parametrised by VAL_W and NUM_DIGITS. The top level keeps the offset/sign logic, held register, output stage and blanking.

Test Plan:
- Speed=27, Load pulse -> after 8 cycles Valid=1, Digits={0000001,0000001,0000001}, Negative=0, Overflow=0.
- Speed=0 -> Digits show 0,2,7 (0000001,0010010,0001111), Negative=1. With SPEED_DISP_LZB_EN: hundreds digit=1111111.
- Speed=127 -> magnitude 100, Digits 1,0,0 (1001111,0000001,0000001). With NUM_DIGITS=2 the same input gives Overflow=1 and both digits 0000100.
- Load at Speed=50; on the next cycle Speed=10 with Load=1 -> the second Load is ignored, and the result shows 023 with Negative=0 and a single Valid pulse.
- DisplayEnable=0 mid-run -> all Digits=1111111 next cycle. Re-enable -> the last result reappears after 1 cycle with no new Load.
- Resetn=0 during CONV cycle 3 -> next cycle Busy=0, Digits all BLANK, no Valid. A following Load converts correctly.
